// File: rtl/risc_ctrl_pkg.sv
// Opcodes, control-word layout and per-opcode control decode for the IITB-RISC decode stage.
package risc_ctrl_pkg;

  localparam int unsigned CTRL_W = 21;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_ADI = 4'b0001;
  localparam logic [3:0] OP_NDU = 4'b0010;
  localparam logic [3:0] OP_LHI = 4'b0011;
  localparam logic [3:0] OP_LW  = 4'b0100;
  localparam logic [3:0] OP_SW  = 4'b0101;
  localparam logic [3:0] OP_LM  = 4'b0110;
  localparam logic [3:0] OP_SM  = 4'b0111;
  localparam logic [3:0] OP_JAL = 4'b1000;
  localparam logic [3:0] OP_JLR = 4'b1001;
  localparam logic [3:0] OP_BEQ = 4'b1100;

  // Control word bit positions (multi-bit fields give their LSB, 2 bits wide)
  localparam int unsigned CB_LOAD_PC      = 0;
  localparam int unsigned CB_SEL_PC_IN    = 1;
  localparam int unsigned CB_LOAD_RF      = 3;
  localparam int unsigned CB_SEL_RF_ADDR  = 4;
  localparam int unsigned CB_SEL_RF_DATA  = 6;
  localparam int unsigned CB_LOAD_C       = 8;
  localparam int unsigned CB_LOAD_Z       = 9;
  localparam int unsigned CB_DMEM_WR      = 10;
  localparam int unsigned CB_SEL_ALU1     = 11;
  localparam int unsigned CB_SEL_ALU2     = 13;
  localparam int unsigned CB_ALU_OP       = 15;
  localparam int unsigned CB_SEL_MEM_ADDR = 17;
  localparam int unsigned CB_CMP_EN       = 18;
  localparam int unsigned CB_SEL_IMM9     = 19;
  localparam int unsigned CB_DMEM_RD      = 20;

  localparam logic [1:0] PCIN_ALU  = 2'b00;
  localparam logic [1:0] PCIN_INC  = 2'b01;
  localparam logic [1:0] PCIN_IMM  = 2'b10;
  localparam logic [1:0] PCIN_RB   = 2'b11;

  localparam logic [1:0] RFA_RA    = 2'b00;
  localparam logic [1:0] RFA_RB    = 2'b01;
  localparam logic [1:0] RFA_SEQ   = 2'b10;
  localparam logic [1:0] RFA_RC    = 2'b11;

  localparam logic [1:0] RFD_ALU   = 2'b00;
  localparam logic [1:0] RFD_MEM   = 2'b01;
  localparam logic [1:0] RFD_IMM   = 2'b10;
  localparam logic [1:0] RFD_PC1   = 2'b11;

  localparam logic [1:0] ALU1_RA   = 2'b00;
  localparam logic [1:0] ALU1_PREV = 2'b01;
  localparam logic [1:0] ALU1_RB   = 2'b10;

  localparam logic [1:0] ALU2_RB   = 2'b00;
  localparam logic [1:0] ALU2_IMM6 = 2'b01;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_NAND = 2'b01;
  localparam logic [1:0] ALUOP_SUB  = 2'b10;

  function automatic logic [CTRL_W-1:0] decode_ctrl(input logic [15:0] instr,
                                                    input logic        first,
                                                    input logic        last);
    logic [CTRL_W-1:0] c;
    c = '0;
    c[CB_LOAD_PC]        = 1'b1;
    c[CB_SEL_PC_IN +: 2] = PCIN_INC;
    case (instr[15:12])
      OP_ADD: begin
        c[CB_LOAD_RF]          = 1'b1;
        c[CB_SEL_RF_ADDR +: 2] = RFA_RC;
        c[CB_LOAD_C]           = 1'b1;
        c[CB_LOAD_Z]           = 1'b1;
      end
      OP_ADI: begin
        c[CB_LOAD_RF]          = 1'b1;
        c[CB_SEL_RF_ADDR +: 2] = RFA_RB;
        c[CB_LOAD_C]           = 1'b1;
        c[CB_LOAD_Z]           = 1'b1;
        c[CB_SEL_ALU2 +: 2]    = ALU2_IMM6;
      end
      OP_NDU: begin
        c[CB_LOAD_RF]          = 1'b1;
        c[CB_SEL_RF_ADDR +: 2] = RFA_RC;
        c[CB_LOAD_Z]           = 1'b1;
        c[CB_ALU_OP +: 2]      = ALUOP_NAND;
      end
      OP_LHI: begin
        c[CB_LOAD_RF]          = 1'b1;
        c[CB_SEL_RF_ADDR +: 2] = RFA_RA;
        c[CB_SEL_RF_DATA +: 2] = RFD_IMM;
        c[CB_SEL_IMM9]         = 1'b1;
      end
      OP_LW: begin
        c[CB_LOAD_RF]          = 1'b1;
        c[CB_SEL_RF_DATA +: 2] = RFD_MEM;
        c[CB_LOAD_Z]           = 1'b1;
        c[CB_SEL_ALU1 +: 2]    = ALU1_RB;
        c[CB_SEL_ALU2 +: 2]    = ALU2_IMM6;
        c[CB_DMEM_RD]          = 1'b1;
      end
      OP_SW: begin
        c[CB_DMEM_WR]          = 1'b1;
        c[CB_SEL_ALU1 +: 2]    = ALU1_RB;
        c[CB_SEL_ALU2 +: 2]    = ALU2_IMM6;
      end
      OP_BEQ: begin
        c[CB_SEL_PC_IN +: 2]   = PCIN_IMM;
        c[CB_CMP_EN]           = 1'b1;
        c[CB_ALU_OP +: 2]      = ALUOP_SUB;
      end
      OP_JAL: begin
        c[CB_SEL_PC_IN +: 2]   = PCIN_IMM;
        c[CB_LOAD_RF]          = 1'b1;
        c[CB_SEL_RF_DATA +: 2] = RFD_PC1;
        c[CB_SEL_IMM9]         = 1'b1;
      end
      OP_JLR: begin
        c[CB_SEL_PC_IN +: 2]   = PCIN_RB;
        c[CB_LOAD_RF]          = 1'b1;
        c[CB_SEL_RF_DATA +: 2] = RFD_PC1;
      end
      OP_LM: begin
        c[CB_LOAD_PC]          = last;
        c[CB_LOAD_RF]          = 1'b1;
        c[CB_SEL_RF_ADDR +: 2] = RFA_SEQ;
        c[CB_SEL_RF_DATA +: 2] = RFD_MEM;
        c[CB_SEL_ALU1 +: 2]    = first ? ALU1_RA : ALU1_PREV;
        c[CB_SEL_MEM_ADDR]     = 1'b1;
        c[CB_DMEM_RD]          = 1'b1;
      end
      OP_SM: begin
        c[CB_LOAD_PC]          = last;
        c[CB_DMEM_WR]          = 1'b1;
        c[CB_SEL_ALU1 +: 2]    = first ? ALU1_RA : ALU1_PREV;
        c[CB_SEL_MEM_ADDR]     = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/lowest_bit_pe.sv
// Lowest-set-bit priority encoder for the LM/SM register mask.
module lowest_bit_pe #(
  parameter int unsigned NUM_REGS   = 8,
  parameter int unsigned REG_ADDR_W = $clog2(NUM_REGS)
) (
  input  logic [NUM_REGS-1:0]   mask_i,
  output logic [REG_ADDR_W-1:0] index_o,
  output logic                  valid_o,
  output logic                  one_left_o
);

  // Scan high to low so the lowest set bit wins
  always_comb begin
    index_o = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (mask_i[i]) index_o = REG_ADDR_W'(i);
    end
  end

  assign valid_o    = |mask_i;
  assign one_left_o = valid_o && ((mask_i & (mask_i - NUM_REGS'(1))) == '0);

endmodule

// File: rtl/decode_sequencer.sv
// Handshaked decode stage: one micro-op per instruction, LM/SM expanded per mask bit.
// Optional performance counters enabled by defining DECODE_PERF_EN.
module decode_sequencer
  import risc_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REGS   = 8,
  parameter int unsigned REG_ADDR_W = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [15:0]           in_instr,
  input  logic [15:0]           in_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [15:0]           out_instr,
  output logic [15:0]           out_pc,
  output logic [CTRL_W-1:0]     out_ctrl,
  output logic [REG_ADDR_W-1:0] out_reg_addr,
  output logic                  out_first,
  output logic                  out_last
`ifdef DECODE_PERF_EN
  ,
  output logic [31:0]           perf_instr_cnt,
  output logic [31:0]           perf_uop_cnt,
  output logic [31:0]           perf_stall_cnt
`endif
);

  localparam logic [1:0] ST_EMPTY  = 2'd0;
  localparam logic [1:0] ST_SINGLE = 2'd1;
  localparam logic [1:0] ST_MULTI  = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [NUM_REGS-1:0]   mask_q, mask_d;
  logic                  valid_d, first_d, last_d;
  logic [15:0]           instr_d, pc_d;
  logic [CTRL_W-1:0]     ctrl_d;
  logic [REG_ADDR_W-1:0] addr_d;

  logic                  accept_c, xfer_c, new_multi_c, new_last_c;
  logic [NUM_REGS-1:0]   pe_mask_c;
  logic [REG_ADDR_W-1:0] pe_idx;
  logic                  pe_valid, pe_one;

  assign in_ready    = ((state_q == ST_EMPTY) || (out_ready && out_last && out_valid)) && !flush;
  assign accept_c    = in_valid && in_ready;
  assign xfer_c      = out_valid && out_ready;
  assign new_multi_c = (in_instr[15:12] == OP_LM) || (in_instr[15:12] == OP_SM);

  // One encoder serves both a freshly accepted mask and the mask left after a transfer
  assign pe_mask_c  = accept_c ? (new_multi_c ? in_instr[NUM_REGS-1:0] : '0)
                               : (mask_q & (mask_q - NUM_REGS'(1)));
  assign new_last_c = !pe_valid || pe_one;

  lowest_bit_pe #(
    .NUM_REGS   (NUM_REGS),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_pe (
    .mask_i     (pe_mask_c),
    .index_o    (pe_idx),
    .valid_o    (pe_valid),
    .one_left_o (pe_one)
  );

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    valid_d = out_valid;
    instr_d = out_instr;
    pc_d    = out_pc;
    ctrl_d  = out_ctrl;
    addr_d  = out_reg_addr;
    first_d = out_first;
    last_d  = out_last;
    if (flush) begin
      state_d = ST_EMPTY;
      valid_d = 1'b0;
      mask_d  = '0;
    end else if (accept_c) begin
      valid_d = 1'b1;
      instr_d = in_instr;
      pc_d    = in_pc;
      first_d = 1'b1;
      if (new_multi_c) begin
        mask_d  = pe_mask_c;
        addr_d  = pe_idx;
        last_d  = new_last_c;
        ctrl_d  = decode_ctrl(in_instr, 1'b1, new_last_c);
        state_d = new_last_c ? ST_SINGLE : ST_MULTI;
        // Empty register list: a lone micro-op that touches neither file nor memory
        if (!pe_valid) begin
          ctrl_d[CB_LOAD_RF] = 1'b0;
          ctrl_d[CB_DMEM_WR] = 1'b0;
          ctrl_d[CB_DMEM_RD] = 1'b0;
        end
      end else begin
        mask_d  = '0;
        addr_d  = '0;
        last_d  = 1'b1;
        ctrl_d  = decode_ctrl(in_instr, 1'b1, 1'b1);
        state_d = ST_SINGLE;
      end
    end else if (xfer_c) begin
      if (out_last) begin
        state_d = ST_EMPTY;
        valid_d = 1'b0;
        mask_d  = '0;
      end else begin
        mask_d  = pe_mask_c;
        addr_d  = pe_idx;
        first_d = 1'b0;
        last_d  = pe_one;
        ctrl_d  = decode_ctrl(out_instr, 1'b0, pe_one);
        state_d = pe_one ? ST_SINGLE : ST_MULTI;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_EMPTY;
      mask_q       <= '0;
      out_valid    <= 1'b0;
      out_instr    <= '0;
      out_pc       <= '0;
      out_ctrl     <= '0;
      out_reg_addr <= '0;
      out_first    <= 1'b0;
      out_last     <= 1'b0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      out_valid    <= valid_d;
      out_instr    <= instr_d;
      out_pc       <= pc_d;
      out_ctrl     <= ctrl_d;
      out_reg_addr <= addr_d;
      out_first    <= first_d;
      out_last     <= last_d;
    end
  end

`ifdef DECODE_PERF_EN
  // Free-running wrap-around counters; flush does not touch them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_instr_cnt <= '0;
      perf_uop_cnt   <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (accept_c)              perf_instr_cnt <= perf_instr_cnt + 32'd1;
      if (xfer_c)                perf_uop_cnt   <= perf_uop_cnt + 32'd1;
      if (in_valid && !in_ready) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_decode_sequencer.sv
// Self-checking bench for decode_sequencer: vector table, directed corner sequences and
// randomized traffic against a micro-op queue model.
module tb_decode_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic [15:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [15:0] out_pc;
  logic [20:0] out_ctrl;
  logic [2:0]  out_reg_addr;
  logic        out_first;
  logic        out_last;
`ifdef DECODE_PERF_EN
  logic [31:0] perf_instr_cnt, perf_uop_cnt, perf_stall_cnt;
`endif

  always #5 clk = ~clk;

  decode_sequencer #(.NUM_REGS(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .in_pc        (in_pc),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_instr    (out_instr),
    .out_pc       (out_pc),
    .out_ctrl     (out_ctrl),
    .out_reg_addr (out_reg_addr),
    .out_first    (out_first),
    .out_last     (out_last)
`ifdef DECODE_PERF_EN
    ,
    .perf_instr_cnt (perf_instr_cnt),
    .perf_uop_cnt   (perf_uop_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
    logic [2:0]  addr;
    logic        first;
    logic        last;
    logic [20:0] ctrl;
  } uop_t;

  typedef struct packed {
    logic [15:0] instr;
    logic [20:0] ctrl;
  } vec_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  uop_t q[$];
  int   m_acc = 0, m_uop = 0, m_stall = 0;
  logic last_in_ready;
  logic [2:0] last_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected control word built from the opcode table plus the LM/SM sequencing rules
  function automatic logic [20:0] exp_ctrl(input logic [15:0] ins, input bit first,
                                           input bit last, input bit zero);
    logic [20:0] b;
    case (ins[15:12])
      4'h0: b = 21'h00033B;
      4'h1: b = 21'h00231B;
      4'h2: b = 21'h00823B;
      4'h3: b = 21'h08008B;
      4'h4: b = 21'h10324B;
      4'h5: b = 21'h003403;
      4'h6: b = 21'h12006A;
      4'h7: b = 21'h020402;
      4'h8: b = 21'h0800CD;
      4'h9: b = 21'h0000CF;
      4'hC: b = 21'h050005;
      default: b = 21'h000003;
    endcase
    if (ins[15:12] == 4'h6 || ins[15:12] == 4'h7) begin
      if (zero) b = (b & ~21'h100408) | 21'h1;
      else      b = b | (first ? 21'h0 : 21'h800) | (last ? 21'h1 : 21'h0);
    end
    return b;
  endfunction

  task automatic expand(input logic [15:0] ins, input logic [15:0] pc);
    uop_t u;
    int   idx[$];
    u.instr = ins;
    u.pc    = pc;
    if (ins[15:12] == 4'h6 || ins[15:12] == 4'h7) begin
      for (int b = 0; b < 8; b++) if (ins[b]) idx.push_back(b);
      if (idx.size() == 0) begin
        u.addr = 3'd0; u.first = 1'b1; u.last = 1'b1; u.ctrl = exp_ctrl(ins, 1, 1, 1);
        q.push_back(u);
      end else begin
        for (int k = 0; k < idx.size(); k++) begin
          u.addr  = 3'(idx[k]);
          u.first = (k == 0);
          u.last  = (k == idx.size() - 1);
          u.ctrl  = exp_ctrl(ins, u.first, u.last, 0);
          q.push_back(u);
        end
      end
    end else begin
      u.addr = 3'd0; u.first = 1'b1; u.last = 1'b1; u.ctrl = exp_ctrl(ins, 1, 1, 0);
      q.push_back(u);
    end
  endtask

  // Sampled on the falling edge: compare presented micro-op and ready, then advance the model
  task automatic model_cycle();
    logic exp_rdy, xfer, acc;
    exp_rdy = !flush && (q.size() == 0 || (out_ready && q.size() == 1));
    last_in_ready = in_ready;
    last_addr     = out_reg_addr;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    if (q.size() != 0 && out_valid) begin
      chk("out_instr", 32'(out_instr), 32'(q[0].instr));
      chk("out_pc", 32'(out_pc), 32'(q[0].pc));
      chk("out_ctrl", 32'(out_ctrl), 32'(q[0].ctrl));
      chk("out_reg_addr", 32'(out_reg_addr), 32'(q[0].addr));
      chk("out_first", 32'(out_first), 32'(q[0].first));
      chk("out_last", 32'(out_last), 32'(q[0].last));
    end
    xfer = (q.size() != 0) && out_ready;
    acc  = in_valid && exp_rdy;
    if (xfer) m_uop++;
    if (acc) m_acc++;
    if (in_valid && !exp_rdy) m_stall++;
    if (flush) q.delete();
    else begin
      if (xfer) void'(q.pop_front());
      if (acc) expand(in_instr, in_pc);
    end
  endtask

  task automatic step(input logic iv, input logic [15:0] ins, input logic [15:0] pc,
                      input logic ordy, input logic fl);
    in_valid = iv; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[13];
  logic [3:0] ops[12];

  initial begin
    int zeros;
    logic [2:0] lm_addrs[4];
    vecs[0]  = '{16'h0298, 21'h00033B};
    vecs[1]  = '{16'h1298, 21'h00231B};
    vecs[2]  = '{16'h2298, 21'h00823B};
    vecs[3]  = '{16'h3123, 21'h08008B};
    vecs[4]  = '{16'h4298, 21'h10324B};
    vecs[5]  = '{16'h5298, 21'h003403};
    vecs[6]  = '{16'hC298, 21'h050005};
    vecs[7]  = '{16'h8123, 21'h0800CD};
    vecs[8]  = '{16'h9280, 21'h0000CF};
    vecs[9]  = '{16'hF000, 21'h000003};
    vecs[10] = '{16'hA000, 21'h000003};
    vecs[11] = '{16'h7200, 21'h020003};
    vecs[12] = '{16'h6000, 21'h020063};
    ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hC, 4'hE};
    lm_addrs = '{3'd0, 3'd2, 3'd5, 3'd7};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_ctrl", 32'(out_ctrl), 32'd0);
    chk("rst_out_fl", {out_first, out_last, out_reg_addr}, 32'd0);
    chk("rst_out_instr_pc", {out_instr, out_pc}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Vector table: each instruction appears one cycle after acceptance
    for (int i = 0; i < 13; i++) begin
      step(1'b1, vecs[i].instr, 16'(16'h100 + i), 1'b1, 1'b0);
      chk("vec_valid", 32'(out_valid), 32'd1);
      chk("vec_ctrl", 32'(out_ctrl), 32'(vecs[i].ctrl));
      chk("vec_first_last", {out_first, out_last}, 32'd3);
      step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    end

    // Back-to-back singles at full rate
    for (int i = 0; i < 4; i++) step(1'b1, 16'(16'h0298 + i), 16'(i), 1'b1, 1'b0);
    step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);

    // LM 0x62A5: registers 0,2,5,7; upstream stalled for three cycles
    step(1'b1, 16'h62A5, 16'h0040, 1'b1, 1'b0);
    zeros = 0;
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
      chk("lm_addr", 32'(last_addr), 32'(lm_addrs[k]));
      if (!last_in_ready) zeros++;
    end
    chk("lm_stall_cycles", 32'(zeros), 32'd3);

    // Backpressure on a single, then on a multi
    step(1'b1, 16'h0298, 16'h0050, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 16'h1111, 16'h0051, 1'b0, 1'b0);
      chk("hold_single_ready", 32'(last_in_ready), 32'd0);
    end
    step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    step(1'b1, 16'h7006, 16'h0060, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b1, 16'h2222, 16'h0061, 1'b0, 1'b0);
    step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    chk("hold_multi_drained", 32'(out_valid), 32'd0);

    // Flush during the second LM micro-op, then a normal ADI
    step(1'b1, 16'h62A5, 16'h0070, 1'b1, 1'b0);
    step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    step(1'b1, 16'h0298, 16'h0071, 1'b1, 1'b1);
    chk("flush_valid", 32'(out_valid), 32'd0);
    step(1'b1, 16'h1298, 16'h0072, 1'b1, 1'b0);
    chk("post_flush_ctrl", 32'(out_ctrl), 32'h231B);
    step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      logic [15:0] ins;
      ins = {ops[$urandom_range(0, 11)], 12'($urandom)};
      step(($urandom_range(0, 9) < 7), ins, 16'($urandom), ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 39) == 0));
    end
    for (int c = 0; c < 10; c++) step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    chk("drain_empty", 32'(q.size()), 32'd0);
`ifdef DECODE_PERF_EN
    chk("perf_instr", perf_instr_cnt, 32'(m_acc));
    chk("perf_uop", perf_uop_cnt, 32'(m_uop));
    chk("perf_stall", perf_stall_cnt, 32'(m_stall));
`endif

    // Reset asserted mid-expansion aborts at once
    step(1'b1, 16'h62A5, 16'h0080, 1'b1, 1'b0);
    step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_ctrl", 32'(out_ctrl), 32'd0);
    chk("rst_mid_addr", {out_first, out_last, out_reg_addr}, 32'd0);
`ifdef DECODE_PERF_EN
    chk("rst_perf", perf_instr_cnt | perf_uop_cnt | perf_stall_cnt, 32'd0);
`endif
    q.delete();
    m_acc = 0; m_uop = 0; m_stall = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 16'h1298, 16'h0090, 1'b1, 1'b0);
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    chk("post_rst_pc", 32'(out_pc), 32'h0090);
    step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
